// File: rtl/iob_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package iob_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index width for N requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_rr_arbiter_if.sv
// Request/grant bundle between requester masters and the arbiter.
interface iob_rr_arbiter_if
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N = 4
) ();

    localparam int N_W = idx_width(N);

    logic [N-1:0]   req_i;
    logic           release_i;
    logic [N-1:0]   gnt_o;
    logic [N_W-1:0] gnt_idx_o;
    logic           gnt_valid_o;

    modport master (
        output req_i,
        output release_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  gnt_valid_o
    );

    modport slave (
        input  req_i,
        input  release_i,
        output gnt_o,
        output gnt_idx_o,
        output gnt_valid_o
    );

endinterface

// File: rtl/iob_rr_arbiter_reg_r.sv
// Resettable register with clock enable: async reset always wins,
// the synchronous reset only takes effect on an enabled edge.
module iob_reg_r #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Storage element: async clear, then enable-qualified sync clear or load.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Round-robin lock arbiter: a grant is held until its owner releases it,
// and the search for the next owner starts just past the previous one.
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             cke_i,
    input  logic             rst_i,
    iob_rr_arbiter_if.slave  bus
);

    localparam int             N_W = idx_width(N);
    localparam logic [N_W:0]   N_L = (N_W + 1)'(N);

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic           state_bits;
    logic [N_W-1:0] ptr_q;
    logic [N_W-1:0] ptr_d;
    logic [N-1:0]   gnt_q;
    logic [N-1:0]   gnt_d;
    logic [N_W-1:0] idx_q;
    logic [N_W-1:0] idx_d;

    logic           any_req;
    logic           win_found;
    logic [N_W-1:0] win_idx;
    logic [N_W:0]   scan;
    logic [N_W:0]   ptr_inc;

    assign any_req = |bus.req_i;
    assign state_q = arb_state_t'(state_bits);

    iob_reg_r #(.DATA_W(1),   .RST_VAL('0)) state_reg (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(state_d), .data_o(state_bits)
    );

    iob_reg_r #(.DATA_W(N_W), .RST_VAL('0)) ptr_reg (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(ptr_d), .data_o(ptr_q)
    );

    iob_reg_r #(.DATA_W(N),   .RST_VAL('0)) gnt_reg (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(gnt_d), .data_o(gnt_q)
    );

    iob_reg_r #(.DATA_W(N_W), .RST_VAL('0)) idx_reg (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .data_i(idx_d), .data_o(idx_q)
    );

    // Circular priority search: first requester at or after ptr, wrapping at N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr_q} + (N_W + 1)'(k);
            if (scan >= N_L) begin
                scan = scan - N_L;
            end
            if (!win_found && bus.req_i[scan[N_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[N_W-1:0];
            end
        end
    end

    // Rotation point after a release: one past the owner, modulo N.
    always_comb begin
        ptr_inc = {1'b0, idx_q} + (N_W + 1)'(1);
        if (ptr_inc >= N_L) begin
            ptr_inc = ptr_inc - N_L;
        end
    end

    // Next state: lock on any request, unlock only on the owner's release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (any_req)        state_d = ARB_BUSY;
            ARB_BUSY: if (bus.release_i)  state_d = ARB_IDLE;
            default:                      state_d = ARB_IDLE;
        endcase
    end

    // Register loads: capture the winner on grant, clear grant and rotate on release.
    always_comb begin
        gnt_d = gnt_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    gnt_d = N'(1) << win_idx;
                    idx_d = win_idx;
                end
            end
            ARB_BUSY: begin
                if (bus.release_i) begin
                    gnt_d = '0;
                    ptr_d = ptr_inc[N_W-1:0];
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_idx_o   = idx_q;
    assign bus.gnt_valid_o = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed test of the round-robin lock arbiter (N=4 and N=1 instances).
module tb_iob_rr_arbiter;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;
    logic cke_i  = 1'b1;
    logic rst_i  = 1'b0;

    int checks = 0;
    int errors = 0;

    iob_rr_arbiter_if #(.N(4)) bus4 ();
    iob_rr_arbiter_if #(.N(1)) bus1 ();

    iob_rr_arbiter #(.N(4)) dut4 (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .bus(bus4.slave)
    );

    iob_rr_arbiter #(.N(1)) dut1 (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i), .bus(bus1.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic [3:0] req, input logic rel,
                                 input logic cke, input logic rst);
        bus4.req_i     = req;
        bus4.release_i = rel;
        cke_i          = cke;
        rst_i          = rst;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt,
                               input logic [1:0] expIdx, input logic expValid);
        checks++;
        assert (bus4.gnt_o === expGnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt_o observed=%b expected=%b", tag, bus4.gnt_o, expGnt);
        end
        checks++;
        assert (bus4.gnt_idx_o === expIdx) else begin
            errors++;
            $error("[TB] FAIL %s gnt_idx_o observed=%0d expected=%0d", tag, bus4.gnt_idx_o, expIdx);
        end
        checks++;
        assert (bus4.gnt_valid_o === expValid) else begin
            errors++;
            $error("[TB] FAIL %s gnt_valid_o observed=%b expected=%b", tag, bus4.gnt_valid_o, expValid);
        end
    endtask

    task automatic checkOutput1(input string tag, input logic expGnt, input logic expValid);
        checks++;
        assert (bus1.gnt_o === expGnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt_o observed=%b expected=%b", tag, bus1.gnt_o, expGnt);
        end
        checks++;
        assert (bus1.gnt_idx_o === 1'b0) else begin
            errors++;
            $error("[TB] FAIL %s gnt_idx_o observed=%0d expected=0", tag, bus1.gnt_idx_o);
        end
        checks++;
        assert (bus1.gnt_valid_o === expValid) else begin
            errors++;
            $error("[TB] FAIL %s gnt_valid_o observed=%b expected=%b", tag, bus1.gnt_valid_o, expValid);
        end
    endtask

    initial begin
        logic [1:0] fairSeq [5];
        fairSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        bus1.req_i     = 1'b0;
        bus1.release_i = 1'b0;
        #12;
        checkOutput("reset4", 4'b0000, 2'd0, 1'b0);
        checkOutput1("reset1", 1'b0, 1'b0);
        arst_i = 1'b0;
        tick();
        checkOutput("idle_noreq", 4'b0000, 2'd0, 1'b0);

        $display("[TB] fairness with all requests held");
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("fair_grant%0d", i), 4'b0001 << fairSeq[i], fairSeq[i], 1'b1);
            applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("fair_idle%0d", i), 4'b0000, fairSeq[i], 1'b0);
            applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] wrap-around from ptr=3");
        applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("owner2", 4'b0100, 2'd2, 1'b1);
        applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rel2", 4'b0000, 2'd2, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap0", 4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rel0", 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("after_wrap2", 4'b0100, 2'd2, 1'b1);

        $display("[TB] async reset mid-BUSY");
        #1;
        arst_i = 1'b1;
        #1;
        checkOutput("arst_now", 4'b0000, 2'd0, 1'b0);
        #1;
        arst_i = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("arst_ptr0", 4'b0001, 2'd0, 1'b1);

        $display("[TB] grant locked while owner drops request");
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rel_a", 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("owner1", 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("locked%0d", i), 4'b0010, 2'd1, 1'b1);
        end
        applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rel1", 4'b0000, 2'd1, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("owner3", 4'b1000, 2'd3, 1'b1);
        applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rel3", 4'b0000, 2'd3, 1'b0);

        $display("[TB] clock enable and synchronous reset");
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("cke_off_a", 4'b0000, 2'd3, 1'b0);
        tick();
        checkOutput("cke_off_b", 4'b0000, 2'd3, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("cke_on", 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("cke_hold_busy", 4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("srst_busy", 4'b0000, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("srst_ptr0", 4'b0001, 2'd0, 1'b1);

        $display("[TB] single requester instance");
        bus1.req_i = 1'b1;
        tick();
        checkOutput1("n1_grant", 1'b1, 1'b1);
        bus1.release_i = 1'b1;
        tick();
        checkOutput1("n1_release", 1'b0, 1'b0);
        bus1.release_i = 1'b0;
        tick();
        checkOutput1("n1_regrant", 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
